// File: rtl/activation_line_buffer_writer_if.sv
// Beat-serial activation stream in, line-buffer port-A write out; grouped so the
// producer/line-buffer side (master) and the fill stage (slave) see one bundle.
interface activation_line_buffer_writer_if #(
    parameter int BANK_W     = 128,
    parameter int BANK_COUNT = 4,
    parameter int AW         = 9
);
    logic [BANK_W-1:0]     s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;
    logic [BANK_W-1:0]     o_activation_buffer_data_in;
    logic                  o_write_port_en;
    logic [BANK_COUNT-1:0] o_write_enable;
    logic [AW-1:0]         o_address_bus;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  o_activation_buffer_data_in, o_write_port_en, o_write_enable, o_address_bus
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output o_activation_buffer_data_in, o_write_port_en, o_write_enable, o_address_bus
    );
endinterface

// File: rtl/activation_line_buffer_writer.sv
// Fills the activation line buffer bank-round-robin from an AXI-S beat stream; 1-cycle beat->write.
// Backpressure: tready is high only while loading, so no beat is taken outside an armed fill.
module activation_line_buffer_writer #(
    parameter int ACTIVATION_BANK_BIT_WIDTH    = 128,
    parameter int ACTIVATION_LINE_BUFFER_DEPTH = 512,
    parameter int ACTIVATION_BUFFER_BANK_COUNT = 4,
    localparam int AW = $clog2(ACTIVATION_LINE_BUFFER_DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 i_start,
    input  logic [AW:0]                          i_word_count,
    activation_line_buffer_writer_if.slave       bus,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_tlast_error
);
    localparam int BC  = ACTIVATION_BUFFER_BANK_COUNT;
    localparam int BW  = ACTIVATION_BANK_BIT_WIDTH;
    localparam int BPW = (BC > 1) ? $clog2(BC) : 1;
    localparam logic [AW:0]    DEPTH_W   = (AW+1)'(ACTIVATION_LINE_BUFFER_DEPTH);
    localparam logic [BPW-1:0] BANK_LAST = BPW'(BC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     count_q, count_d;
    logic [BPW-1:0]  bank_ptr_q, bank_ptr_d;
    logic [AW-1:0]   addr_ptr_q, addr_ptr_d;
    logic            tlast_err_q, tlast_err_d;
    logic            wpe_q, wpe_d;
    logic [BC-1:0]   we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [BW-1:0]   wdat_q, wdat_d;

    logic start_ok;
    logic beat_acc;
    logic final_beat;

    // Out-of-range counts are dropped here so they never disturb an idle block.
    assign start_ok   = (state_q == IDLE) && i_start && (i_word_count <= DEPTH_W);
    assign beat_acc   = bus.s_axis_tvalid && bus.s_axis_tready;
    assign final_beat = ({1'b0, addr_ptr_q} == (count_q - (AW+1)'(1))) && (bank_ptr_q == BANK_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = (i_word_count == '0) ? DONE : LOAD;
            LOAD:    if (beat_acc && final_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_axis_tready = (state_q == LOAD);
        o_busy            = (state_q == LOAD);
        o_done            = (state_q == DONE);
    end

    always_comb begin
        count_d     = count_q;
        bank_ptr_d  = bank_ptr_q;
        addr_ptr_d  = addr_ptr_q;
        tlast_err_d = tlast_err_q;
        wpe_d       = 1'b0;
        we_d        = '0;
        waddr_d     = waddr_q;
        wdat_d      = wdat_q;
        if (start_ok) begin
            count_d     = i_word_count;
            bank_ptr_d  = '0;
            addr_ptr_d  = '0;
            tlast_err_d = 1'b0;
        end
        if (beat_acc) begin
            wpe_d   = 1'b1;
            we_d    = BC'(1) << bank_ptr_q;
            waddr_d = addr_ptr_q;
            wdat_d  = bus.s_axis_tdata;
            if (bank_ptr_q == BANK_LAST) begin
                bank_ptr_d = '0;
                addr_ptr_d = addr_ptr_q + AW'(1);
            end else begin
                bank_ptr_d = bank_ptr_q + BPW'(1);
            end
            // tlast is advisory: a misplaced or missing marker is flagged, never acted on.
            if (bus.s_axis_tlast != final_beat) tlast_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q     <= '0;
            bank_ptr_q  <= '0;
            addr_ptr_q  <= '0;
            tlast_err_q <= 1'b0;
            wpe_q       <= 1'b0;
            we_q        <= '0;
            waddr_q     <= '0;
            wdat_q      <= '0;
        end else begin
            count_q     <= count_d;
            bank_ptr_q  <= bank_ptr_d;
            addr_ptr_q  <= addr_ptr_d;
            tlast_err_q <= tlast_err_d;
            wpe_q       <= wpe_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdat_q      <= wdat_d;
        end
    end

    assign bus.o_write_port_en             = wpe_q;
    assign bus.o_write_enable              = we_q;
    assign bus.o_address_bus               = waddr_q;
    assign bus.o_activation_buffer_data_in = wdat_q;
    assign o_tlast_error                   = tlast_err_q;
endmodule

// File: tb/tb_activation_line_buffer_writer.sv
// Randomized fills against a beat-index reference model; a negedge monitor pops
// expected port-A writes and bare done pulses from scoreboard queues.
module tb_activation_line_buffer_writer;
    localparam int BW    = 128;
    localparam int DEPTH = 512;
    localparam int BC    = 4;
    localparam int AW    = 9;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BC-1:0] we;
        logic [BW-1:0] data;
        logic          done;
        logic          err;
    } wr_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          i_start = 1'b0;
    logic [AW:0]   i_word_count = '0;
    logic          o_busy, o_done, o_tlast_error;

    activation_line_buffer_writer_if #(.BANK_W(BW), .BANK_COUNT(BC), .AW(AW)) bus();

    activation_line_buffer_writer #(
        .ACTIVATION_BANK_BIT_WIDTH   (BW),
        .ACTIVATION_LINE_BUFFER_DEPTH(DEPTH),
        .ACTIVATION_BUFFER_BANK_COUNT(BC)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_start      (i_start),
        .i_word_count (i_word_count),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_tlast_error(o_tlast_error)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  done_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  model_err = 1'b0;
    wr_t mon_act, mon_exp;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every port-A write must match the next expected write; a done
    // pulse without a write must match an expected empty fill.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.o_write_port_en) begin
                checks++;
                mon_act.addr = bus.o_address_bus;
                mon_act.we   = bus.o_write_enable;
                mon_act.data = bus.o_activation_buffer_data_in;
                mon_act.done = o_done;
                mon_act.err  = o_tlast_error;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected addr=%0h we=%0h required=no_write",
                             mon_act.addr, mon_act.we);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL write actual addr=%0h we=%0h data=%0h done=%0b err=%0b required addr=%0h we=%0h data=%0h done=%0b err=%0b",
                                 mon_act.addr, mon_act.we, mon_act.data, mon_act.done, mon_act.err,
                                 mon_exp.addr, mon_exp.we, mon_exp.data, mon_exp.done, mon_exp.err);
                    end
                end
                if (o_done) chk("busy_with_done", o_busy, 0);
            end else begin
                chk("we_idle", bus.o_write_enable, 0);
                if (o_done) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected actual=1 required=0");
                    end else begin
                        void'(done_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [BW-1:0] d, input bit tl, output bit ok);
        int t;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = tl;
        bus.s_axis_tvalid = 1'b1;
        t = 0;
        while (!bus.s_axis_tready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        ok = bus.s_axis_tready;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout actual=0 required=1");
            bus.s_axis_tvalid = 1'b0;
        end else begin
            @(posedge clk); #1;
            bus.s_axis_tvalid = 1'b0;
        end
    endtask

    task automatic start(input int count);
        i_start      = 1'b1;
        i_word_count = (AW+1)'(count);
        @(posedge clk); #1;
        i_start = 1'b0;
        if (count <= DEPTH) begin
            model_err = 1'b0;
            if (count == 0) done_q.push_back(1);
        end
    endtask

    // Beat k of a fill lands at address k/BC in bank k%BC; only the last beat may carry tlast.
    task automatic run_fill(input int count, input int bad_idx, input bit final_tlast,
                            input int gap_pct, input bit glitch, input int stop_after);
        int n;
        bit ok, fin, tl;
        logic [BW-1:0] d;
        wr_t e;
        n = count * BC;
        if (stop_after >= 0 && stop_after < n) n = stop_after;
        for (int k = 0; k < n; k++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                @(posedge clk); #1;
            end
            d   = {$urandom, $urandom, $urandom, $urandom};
            fin = (k == count * BC - 1);
            tl  = fin ? final_tlast : (k == bad_idx);
            if (glitch && (k % 300) == 7) begin
                i_start      = 1'b1;
                i_word_count = (AW+1)'($urandom_range(1, DEPTH));
            end
            send_beat(d, tl, ok);
            i_start = 1'b0;
            if (!ok) return;
            if (tl != fin) model_err = 1'b1;
            e.addr = AW'(k / BC);
            e.we   = BC'(1) << (k % BC);
            e.data = d;
            e.done = fin;
            e.err  = model_err;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((o_busy || o_done) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk({name, "_terminates"}, (t < 100), 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk({name, "_writes_drained"}, exp_q.size(), 0);
        chk({name, "_done_drained"}, done_q.size(), 0);
        chk({name, "_tlast_error"}, o_tlast_error, model_err);
        chk({name, "_tready_idle"}, bus.s_axis_tready, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        #12;
        chk("reset_ctrl", {o_busy, o_done, o_tlast_error, bus.s_axis_tready,
                           bus.o_write_port_en, bus.o_write_enable}, 0);
        chk("reset_addr", bus.o_address_bus, 0);
        chk("reset_data_nonzero", |bus.o_activation_buffer_data_in, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        start(2);
        run_fill(2, -1, 1'b1, 0, 1'b0, -1);
        wait_idle("fill2_b2b");

        start(2);
        run_fill(2, -1, 1'b1, 100, 1'b0, -1);
        wait_idle("fill2_toggle");

        start(1);
        run_fill(1, 1, 1'b1, 0, 1'b0, -1);
        wait_idle("early_tlast");
        start(2);
        chk("tlast_error_cleared", o_tlast_error, 0);
        run_fill(2, -1, 1'b1, 30, 1'b0, -1);
        wait_idle("fill2_random_gaps");

        start(0);
        wait_idle("count_zero");

        start(1);
        run_fill(1, -1, 1'b0, 20, 1'b0, -1);
        wait_idle("missing_tlast");

        start(DEPTH + 1);
        repeat (3) begin
            chk("oversize_busy", o_busy, 0);
            chk("oversize_tready", bus.s_axis_tready, 0);
            @(posedge clk); #1;
        end
        chk("oversize_keeps_error", o_tlast_error, 1);

        start(DEPTH);
        run_fill(DEPTH, -1, 1'b1, 10, 1'b1, -1);
        wait_idle("full_depth");

        start(2);
        run_fill(2, -1, 1'b1, 0, 1'b0, 5);
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("async_reset_ctrl", {o_busy, o_done, o_tlast_error, bus.s_axis_tready,
                                 bus.o_write_port_en, bus.o_write_enable}, 0);
        chk("async_reset_addr", bus.o_address_bus, 0);
        exp_q.delete();
        done_q.delete();
        model_err = 1'b0;
        #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_tready", bus.s_axis_tready, 0);
        chk("post_reset_busy", o_busy, 0);
        start(1);
        run_fill(1, -1, 1'b1, 0, 1'b0, -1);
        wait_idle("post_reset_fill");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
